// File: rtl/drp_reconfig_master.sv
// DRP initiator for the ADPLL: one read, write or read-modify-write at a time.
// Can hold the PLL in reset across the write and then wait for it to relock.
module drp_reconfig_master #(
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 16,
  parameter int DRP_TIMEOUT  = 64,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic              dclk_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_op_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_data_i,
  input  logic [DATA_W-1:0] req_mask_i,
  input  logic              req_relock_i,
  output logic              rsp_valid_o,
  output logic [1:0]        rsp_status_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic [ADDR_W-1:0] daddr_o,
  output logic [DATA_W-1:0] di_o,
  output logic              den_o,
  output logic              dwe_o,
  input  logic [DATA_W-1:0] do_i,
  input  logic              drdy_i,
  output logic              pll_rst_o,
  input  logic              locked_i
);

  localparam int DCW = $clog2(DRP_TIMEOUT + 1);
  localparam int LCW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [DCW-1:0] DRP_LAST  = DCW'(DRP_TIMEOUT - 1);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_TIMEOUT - 1);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_RMW   = 2'b10;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_DRP_TO   = 2'b01;
  localparam logic [1:0] ST_LOCK_TO  = 2'b10;
  localparam logic [1:0] ST_ILLEGAL  = 2'b11;

  typedef enum logic [2:0] {
    IDLE, RD_EN, RD_WAIT, WR_EN, WR_WAIT, RELOCK, RESP
  } state_e;

  state_e             state_q;
  logic [1:0]         op_q;
  logic [DATA_W-1:0]  data_q;
  logic [DATA_W-1:0]  mask_q;
  logic               relock_q;
  logic [DATA_W-1:0]  rd_data_q;
  logic [DCW-1:0]     drp_cnt_q;
  logic [LCW-1:0]     lock_cnt_q;
  logic               req_ready_q;
  logic               rsp_valid_q;
  logic [1:0]         rsp_status_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic [ADDR_W-1:0]  daddr_q;
  logic [DATA_W-1:0]  di_q;
  logic               den_q;
  logic               dwe_q;
  logic               pll_rst_q;

  logic [DATA_W-1:0]  rmw_wdata_d;
  logic [DATA_W-1:0]  wr_rsp_data_d;

  // RMW merge uses DO directly so the write can start the cycle after read DRDY.
  assign rmw_wdata_d   = (do_i & mask_q) | (data_q & ~mask_q);
  assign wr_rsp_data_d = (op_q == OP_RMW) ? rd_data_q : di_q;

  always_ff @(posedge dclk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      op_q         <= '0;
      data_q       <= '0;
      mask_q       <= '0;
      relock_q     <= 1'b0;
      rd_data_q    <= '0;
      drp_cnt_q    <= '0;
      lock_cnt_q   <= '0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= '0;
      rsp_data_q   <= '0;
      daddr_q      <= '0;
      di_q         <= '0;
      den_q        <= 1'b0;
      dwe_q        <= 1'b0;
      pll_rst_q    <= 1'b0;
    end else begin
      den_q       <= 1'b0;
      dwe_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            op_q        <= req_op_i;
            data_q      <= req_data_i;
            mask_q      <= req_mask_i;
            relock_q    <= req_relock_i && (req_op_i != OP_READ);
            daddr_q     <= req_addr_i;
            drp_cnt_q   <= '0;
            req_ready_q <= 1'b0;
            case (req_op_i)
              OP_READ: begin
                state_q <= RD_EN;
                den_q   <= 1'b1;
              end
              OP_WRITE: begin
                state_q   <= WR_EN;
                den_q     <= 1'b1;
                dwe_q     <= 1'b1;
                di_q      <= req_data_i;
                pll_rst_q <= req_relock_i;
              end
              OP_RMW: begin
                state_q   <= RD_EN;
                den_q     <= 1'b1;
                pll_rst_q <= req_relock_i;
              end
              default: begin
                state_q      <= RESP;
                rsp_valid_q  <= 1'b1;
                rsp_status_q <= ST_ILLEGAL;
                rsp_data_q   <= '0;
              end
            endcase
          end
        end
        RD_EN: begin
          state_q   <= RD_WAIT;
          drp_cnt_q <= drp_cnt_q + DCW'(1);
        end
        RD_WAIT: begin
          if (drdy_i) begin
            rd_data_q <= do_i;
            if (op_q == OP_READ) begin
              state_q      <= RESP;
              rsp_valid_q  <= 1'b1;
              rsp_status_q <= ST_OK;
              rsp_data_q   <= do_i;
            end else begin
              state_q   <= WR_EN;
              den_q     <= 1'b1;
              dwe_q     <= 1'b1;
              di_q      <= rmw_wdata_d;
              drp_cnt_q <= '0;
            end
          end else if (drp_cnt_q == DRP_LAST) begin
            state_q      <= RESP;
            rsp_valid_q  <= 1'b1;
            rsp_status_q <= ST_DRP_TO;
            rsp_data_q   <= '0;
            pll_rst_q    <= 1'b0;
          end else begin
            drp_cnt_q <= drp_cnt_q + DCW'(1);
          end
        end
        WR_EN: begin
          state_q   <= WR_WAIT;
          drp_cnt_q <= drp_cnt_q + DCW'(1);
        end
        WR_WAIT: begin
          if (drdy_i) begin
            if (relock_q) begin
              state_q    <= RELOCK;
              pll_rst_q  <= 1'b0;
              lock_cnt_q <= '0;
            end else begin
              state_q      <= RESP;
              rsp_valid_q  <= 1'b1;
              rsp_status_q <= ST_OK;
              rsp_data_q   <= wr_rsp_data_d;
            end
          end else if (drp_cnt_q == DRP_LAST) begin
            state_q      <= RESP;
            rsp_valid_q  <= 1'b1;
            rsp_status_q <= ST_DRP_TO;
            rsp_data_q   <= '0;
            pll_rst_q    <= 1'b0;
          end else begin
            drp_cnt_q <= drp_cnt_q + DCW'(1);
          end
        end
        RELOCK: begin
          // LOCKED is ignored on the first cycle: the PLL needs a cycle to drop it.
          if ((lock_cnt_q != '0) && locked_i) begin
            state_q      <= RESP;
            rsp_valid_q  <= 1'b1;
            rsp_status_q <= ST_OK;
            rsp_data_q   <= wr_rsp_data_d;
          end else if (lock_cnt_q == LOCK_LAST) begin
            state_q      <= RESP;
            rsp_valid_q  <= 1'b1;
            rsp_status_q <= ST_LOCK_TO;
            rsp_data_q   <= '0;
          end else begin
            lock_cnt_q <= lock_cnt_q + LCW'(1);
          end
        end
        RESP: begin
          state_q      <= IDLE;
          req_ready_q  <= 1'b1;
          rsp_status_q <= '0;
          rsp_data_q   <= '0;
          pll_rst_q    <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          pll_rst_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_status_o = rsp_status_q;
  assign rsp_data_o   = rsp_data_q;
  assign daddr_o      = daddr_q;
  assign di_o         = di_q;
  assign den_o        = den_q;
  assign dwe_o        = dwe_q;
  assign pll_rst_o    = pll_rst_q;

endmodule
